// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and constants for the multdiv sequencer
package multdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } md_state_e;

    localparam logic        OP_MUL         = 1'b0;
    localparam logic        OP_DIV         = 1'b1;
    localparam logic [4:0]  REG_RSTATUS    = 5'd30;
    localparam logic [31:0] DEF_STATUS_MUL = 32'd4;
    localparam logic [31:0] DEF_STATUS_DIV = 32'd5;
    localparam int          DEF_WAIT_MAX   = 40;

    // Status code that replaces the result when the operation faulted.
    function automatic logic [31:0] status_code(input logic        op,
                                                input logic [31:0] s_mul,
                                                input logic [31:0] s_div);
        return (op == OP_DIV) ? s_div : s_mul;
    endfunction

endpackage

// File: rtl/md_watchdog.sv
// rtl/md_watchdog.sv - saturating wait counter with timeout flag
// Ports: i_clk/i_rst_n clock and async active-low reset; i_clear zeroes the
// count; i_enable advances it; o_expired is high once the count reaches
// WAIT_MAX-1 (the count then holds instead of wrapping).
module md_watchdog #(
    parameter int WAIT_MAX = 40
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int            CW   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - pipeline-side sequencer for a multi-cycle mul/div unit
// Ports: i_req_* is the X-stage request, i_flush aborts it; o_ctrl_MULT /
// o_ctrl_DIV and o_md_a/o_md_b drive the multdiv unit, i_md_* return its
// result; o_stall freezes the pipeline; o_resp_* is the one-cycle writeback
// strobe; o_busy is high whenever the sequencer is not idle.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int          WAIT_MAX   = DEF_WAIT_MAX,
    parameter logic [31:0] STATUS_MUL = DEF_STATUS_MUL,
    parameter logic [31:0] STATUS_DIV = DEF_STATUS_DIV
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    input  logic        i_req_op,
    input  logic [31:0] i_req_a,
    input  logic [31:0] i_req_b,
    input  logic [4:0]  i_req_rd,
    input  logic        i_flush,
    output logic        o_ctrl_MULT,
    output logic        o_ctrl_DIV,
    output logic [31:0] o_md_a,
    output logic [31:0] o_md_b,
    input  logic [31:0] i_md_result,
    input  logic        i_md_exception,
    input  logic        i_md_resultRDY,
    output logic        o_stall,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_data,
    output logic [4:0]  o_resp_rd,
    output logic        o_busy
);

    md_state_e   r_state;
    md_state_e   w_next;
    logic        r_op;
    logic [4:0]  r_rd;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_result;
    logic        r_exc;

    logic        w_accept;
    logic        w_capture;
    logic        w_timeout;
    logic        w_pulse;
    logic        w_wd_clear;
    logic        w_wd_en;
    logic        w_expired;

    md_watchdog #(.WAIT_MAX(WAIT_MAX)) u_watchdog (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Flush is checked ahead of RDY/timeout so an aborted operation never
    // reaches DONE.
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_capture  = 1'b0;
        w_timeout  = 1'b0;
        w_pulse    = 1'b0;
        w_wd_clear = 1'b0;
        w_wd_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_req_valid && !i_flush) begin
                    w_accept = 1'b1;
                    w_next   = ST_START;
                end
            end
            ST_START: begin
                w_wd_clear = 1'b1;
                if (i_flush) begin
                    w_next = ST_IDLE;
                end else begin
                    w_pulse = 1'b1;
                    w_next  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_wd_en = 1'b1;
                if (i_flush) begin
                    w_next = ST_IDLE;
                end else if (i_md_resultRDY) begin
                    w_capture = 1'b1;
                    w_next    = ST_DONE;
                end else if (w_expired) begin
                    w_capture = 1'b1;
                    w_timeout = 1'b1;
                    w_next    = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op     <= OP_MUL;
            r_rd     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op <= i_req_op;
                r_rd <= i_req_rd;
                r_a  <= i_req_a;
                r_b  <= i_req_b;
            end
            if (w_capture) begin
                r_result <= w_timeout ? '0 : i_md_result;
                r_exc    <= w_timeout ? 1'b1 : i_md_exception;
            end
        end
    end

    assign o_ctrl_MULT  = w_pulse && (r_op == OP_MUL);
    assign o_ctrl_DIV   = w_pulse && (r_op == OP_DIV);
    assign o_md_a       = r_a;
    assign o_md_b       = r_b;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_stall      = i_req_valid && (r_state != ST_DONE);
    // A flush landing in DONE drops the response as well.
    assign o_resp_valid = (r_state == ST_DONE) && !i_flush;
    assign o_resp_data  = !o_resp_valid ? '0 :
                          r_exc ? status_code(r_op, STATUS_MUL, STATUS_DIV) : r_result;
    assign o_resp_rd    = !o_resp_valid ? '0 : (r_exc ? REG_RSTATUS : r_rd);

endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 SHALL have parameter: WAIT_MAX, 40, maximum WAIT cycles before a forced exception.
REQ-002 SHALL have parameter: STATUS_MUL, 4, status code written on mul exception.
REQ-003 SHALL have parameter: STATUS_DIV, 5, status code written on div exception.
REQ-004 SHALL have: clock  in  1  master clock; all state on rising edge.
REQ-005 SHALL have: reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have: req_valid  in  1  X stage holds a mul/div.
REQ-007 SHALL have: req_op  in  1  0 = mul, 1 = div.
REQ-008 SHALL have: req_a, req_b  in  32  operands, bypassed values.
REQ-009 SHALL have: req_rd  in  5  destination register.
REQ-010 SHALL have: flush  in  1  abort the current operation (branch/jump taken).
REQ-011 SHALL have: ctrl_MULT, ctrl_DIV  out  1  start pulses to the multdiv unit.
REQ-012 SHALL have: md_a, md_b  out  32  latched operands to the multdiv unit.
REQ-013 SHALL have: md_result  in  32  result from the multdiv unit.
REQ-014 SHALL have: md_exception  in  1  exception flag from the multdiv unit.
REQ-015 SHALL have: md_resultRDY  in  1  ready flag from the multdiv unit.
REQ-016 SHALL have: stall  out  1  freeze PC, FD, DX, XM and MW latches.
REQ-017 SHALL have: resp_valid  out  1  one-cycle result strobe.
REQ-018 SHALL have: resp_data  out  32  result or status code.
REQ-019 SHALL have: resp_rd  out  5  writeback register.
REQ-020 SHALL have: busy  out  1  state != IDLE.

Function
REQ-021 SHALL implement FSM IDLE, START, WAIT, DONE.
REQ-022 IDLE: req_valid & ~flush SHALL latch req_a, req_b, req_op, req_rd into md_a, md_b and internal registers, then go to START.
REQ-023 START: SHALL assert exactly one of ctrl_MULT/ctrl_DIV (per latched op) for one cycle, clear the wait counter, go to WAIT.
REQ-024 WAIT: counter SHALL increment each cycle; md_resultRDY SHALL latch md_result and md_exception and go to DONE.
REQ-025 WAIT: counter == WAIT_MAX-1 without RDY SHALL go to DONE with exception forced to 1.
REQ-026 DONE: SHALL assert resp_valid for one cycle, then go to IDLE.
REQ-027 resp_data SHALL be STATUS_DIV or STATUS_MUL (per op) on exception, otherwise the latched result.
REQ-028 resp_rd SHALL be 5'd30 on exception, otherwise the latched req_rd.
REQ-029 stall SHALL equal req_valid & (state != DONE); it is combinational and high in the request's first IDLE cycle.
REQ-030 Latency: resp_valid SHALL occur exactly one cycle after the cycle in which RDY is sampled in WAIT.
REQ-031 md_resultRDY outside WAIT SHALL be ignored, including RDY in the START cycle.
REQ-032 flush in any state SHALL return the FSM to IDLE next cycle with no resp_valid; flush in START SHALL suppress the start pulse.
REQ-033 flush concurrent with RDY in WAIT SHALL take priority: no response.
REQ-034 After DONE, a back-to-back request in IDLE SHALL be accepted immediately; the new start pulse restarts the multdiv unit.
REQ-035 Counter width SHALL be $clog2(WAIT_MAX) and SHALL NOT wrap.

Reset
REQ-036 reset low SHALL asynchronously force IDLE, counter 0, and all latched registers 0.
REQ-037 Reset values SHALL be 0 on all outputs (ctrl_MULT, ctrl_DIV, md_a, md_b, resp_valid, resp_data, resp_rd, busy); stall = req_valid.
REQ-038 Reset mid-operation SHALL abandon the operation silently; a later RDY SHALL be ignored.

Structure
REQ-039 Shared package multdiv_pkg SHALL hold the state enum, OP_MUL/OP_DIV, REG_RSTATUS = 30, and default status codes.
REQ-040 Wait counter and timeout compare SHALL be the sub-module md_watchdog (clear, enable, expired).

Verification
REQ-041 mul 7*6, RDY 33 cycles after pulse -> one ctrl_MULT pulse, stall high throughout; resp_valid one cycle after RDY, resp_data = 42, resp_rd = req_rd.
REQ-042 div 100/0 with md_exception = 1 -> resp_data = 5, resp_rd = 30.
REQ-043 RDY never asserted, WAIT_MAX = 40 -> DONE after 40 WAIT cycles; mul gives resp_data = 4, resp_rd = 30.
REQ-044 flush in START, then flush again in WAIT concurrent with RDY -> no ctrl pulse in the first case, no resp_valid in either, FSM in IDLE.
REQ-045 Back-to-back mul 3*3 then div 9/3 -> two pulses, resp_data 9 then 3, no lost or duplicate resp_valid.
REQ-046 reset low in WAIT, RDY pulsed after release -> outputs 0, no resp_valid.
